// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the sequential ALU:
//   alucontrol_t  - 4-bit operation encodings (legacy 3-bit ops zero-extended)
//   state_t       - handshake FSM states
//   is_multicycle - true for the iterative mul/mulhu/divu/remu group
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_XOR   = 4'b0011,
    ALU_SLL   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SLT   = 4'b0111,
    ALU_MUL   = 4'b1000,
    ALU_MULHU = 4'b1001,
    ALU_DIVU  = 4'b1010,
    ALU_REMU  = 4'b1011,
    ALU_SRA   = 4'b1101,
    ALU_SLTU  = 4'b1111
  } alucontrol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The iterative group occupies 10xx: bit 1 selects divide, bit 0 selects
  // the upper half (mulhu / remu).
  function automatic logic is_multicycle(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// ---------------------------------------------------------------------------
// iter_muldiv
// One-bit-per-cycle unsigned multiply (shift-add) and divide (restoring).
// A single 2*WIDTH accumulator is shared:
//   multiply: {partial product high, remaining multiplier bits}
//   divide:   {partial remainder, dividend bits / quotient bits}
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - load a, b and op; iteration begins next cycle
//   op[1:0]     - bit 1: divide (else multiply); bit 0: upper half result
//   a, b        - operands (multiplicand/multiplier or dividend/divisor)
//   done        - high during the cycle that performs the final iteration
//   result      - value of the selected half after that final iteration,
//                 valid while done is high
// ---------------------------------------------------------------------------
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_TERM = CW'(WIDTH);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 active_q, active_d;
  logic                 is_div_q, is_div_d;
  logic                 sel_hi_q, sel_hi_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;     // multiplicand or divisor
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       diff;

  // One iteration of the selected algorithm applied to the accumulator.
  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole product right by one.
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    // Restoring divide: bring the next dividend bit into the remainder and
    // trial-subtract the divisor; a borrow means restore.
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (is_div_q) begin
      if (diff[WIDTH]) begin
        acc_step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = {sum, acc_q[WIDTH-1:1]};
    end
  end

  assign done   = active_q && (cnt_q == CNT_LAST);
  assign result = sel_hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      is_div_d = op[1];
      sel_hi_d = op[0];
      opnd_d   = op[1] ? b : a;
      acc_d    = {{WIDTH{1'b0}}, (op[1] ? a : b)};
    end else if (active_q) begin
      acc_d = acc_step;
      // Counter stops at the terminal count rather than wrapping.
      if (cnt_q != CNT_TERM) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_q == CNT_LAST) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// ops and divide-by-zero complete in one cycle; mul/mulhu/divu/remu iterate
// WIDTH cycles in iter_muldiv.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid / in_ready   - operation handshake (srca, srcb, alucontrol)
//   out_valid / out_ready - result handshake (aluresult, zero)
//   aluresult, zero       - registered result and result==0 flag
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aluresult_q, aluresult_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] single_result;
  logic [SHW-1:0]   shamt;
  logic             div_by_zero;
  logic             go_iter;
  logic             accept;
  logic             iter_start;
  logic             iter_done;
  logic [WIDTH-1:0] iter_result;

  assign shamt       = srcb[SHW-1:0];
  assign div_by_zero = (srcb == '0);
  // Divide by zero is answered directly instead of iterating.
  assign go_iter     = is_multicycle(alucontrol) && !(alucontrol[1] && div_by_zero);

  // Single-cycle results; illegal opcodes fall through to zero.
  always_comb begin
    single_result = '0;
    case (alucontrol)
      ALU_ADD:  single_result = srca + srcb;
      ALU_SUB:  single_result = srca - srcb;
      ALU_AND:  single_result = srca & srcb;
      ALU_OR:   single_result = srca | srcb;
      ALU_XOR:  single_result = srca ^ srcb;
      ALU_SLT:  single_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLTU: single_result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      ALU_SLL:  single_result = srca << shamt;
      ALU_SRL:  single_result = srca >> shamt;
      ALU_SRA:  single_result = $unsigned($signed(srca) >>> shamt);
      ALU_DIVU: single_result = '1;    // only reached when srcb == 0
      ALU_REMU: single_result = srca;  // only reached when srcb == 0
      default:  single_result = '0;
    endcase
  end

  // DONE also accepts a new op when the current result is being consumed.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign aluresult = aluresult_q;
  assign zero      = zero_q;

  always_comb begin
    state_d     = state_q;
    aluresult_d = aluresult_q;
    zero_d      = zero_q;
    iter_start  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready && !in_valid) begin
          state_d = IDLE;
        end
        if (accept) begin
          if (go_iter) begin
            iter_start = 1'b1;
            state_d    = BUSY;
          end else begin
            aluresult_d = single_result;
            zero_d      = (single_result == '0);
            state_d     = DONE;
          end
        end
      end
      BUSY: begin
        if (iter_done) begin
          aluresult_d = iter_result;
          zero_d      = (iter_result == '0);
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      aluresult_q <= '0;
      zero_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      aluresult_q <= aluresult_d;
      zero_q      <= zero_d;
    end
  end

  iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_iter_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (iter_start),
    .op     (alucontrol[1:0]),
    .a      (srca),
    .b      (srcb),
    .done   (iter_done),
    .result (iter_result)
  );

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq (WIDTH=32): reset values, back-to-back
// single-cycle ops, multiply/divide latency and results, divide by zero,
// output backpressure, and reset in the middle of a divide.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic [3:0]   alucontrol;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] aluresult;
  logic         zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluresult  (aluresult),
    .zero       (zero)
  );

  // Back-to-back vectors: op, a, b, expected result, expected zero.
  logic [3:0]   b2b_op  [10] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA,
                                 ALU_SLL, ALU_SRL, ALU_XOR, 4'b1100, ALU_OR};
  logic [W-1:0] b2b_a   [10] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'd1, 32'h8000_0000, 32'hF0F0_F0F0,
                                 32'd3, 32'h0000_000F};
  logic [W-1:0] b2b_b   [10] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd4, 32'h23, 32'd31,
                                 32'hFF00_FF00, 32'd4, 32'h0000_00F0};
  logic [W-1:0] b2b_exp [10] = '{32'h8000_0000, 32'd0, 32'd1, 32'd0, 32'hF800_0000,
                                 32'd8, 32'd1, 32'h0FF0_0FF0, 32'd0, 32'h0000_00FF};
  logic         b2b_z   [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE with out_ready high; report edges from
  // acceptance to out_valid (acceptance edge counts as 1), then consume.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat,
                        output logic [W-1:0] res, output logic z);
    alucontrol = op;
    srca       = a;
    srcb       = b;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    tick();
    lat = 1;
    // Scribble the operand bus: the op in flight must not notice.
    in_valid   = 1'b0;
    srca       = 32'hDEAD_BEEF;
    srcb       = 32'h0BAD_F00D;
    alucontrol = ALU_SUB;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    res = aluresult;
    z   = zero;
    $display("[TB] op=%b a=%h b=%h -> result=%h zero=%b latency=%0d", op, a, b, res, z, lat);
    tick();
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    srca       = '0;
    srcb       = '0;
    alucontrol = '0;
    tick();
    tick();
    reset = 1'b0;
    $display("[TB] reset released: in_ready=%b out_valid=%b aluresult=%h zero=%b",
             in_ready, out_valid, aluresult, zero);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (aluresult !== 32'd0) begin fails++; $display("FAIL reset_aluresult: got %h want 0", aluresult); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero: got %b want 1", zero); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alucontrol = b2b_op[i];
      srca       = b2b_a[i];
      srcb       = b2b_b[i];
      in_valid   = 1'b1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
      $display("[TB] b2b op=%b a=%h b=%h -> result=%h zero=%b out_valid=%b",
               b2b_op[i], b2b_a[i], b2b_b[i], aluresult, zero, out_valid);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (aluresult !== b2b_exp[i]) begin fails++; $display("FAIL b2b_result[%0d]: got %h want %h", i, aluresult, b2b_exp[i]); end
      tests++; if (zero !== b2b_z[i]) begin fails++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero, b2b_z[i]); end
    end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_mul();
    int lat;
    logic [W-1:0] res;
    logic z;
    run_op(ALU_MUL, 32'hFFFF_FFFF, 32'd2, lat, res, z);
    tests++; if (lat != 33) begin fails++; $display("FAIL mul_latency: got %0d want 33", lat); end
    tests++; if (res !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mul_result: got %h want fffffffe", res); end
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, lat, res, z);
    tests++; if (lat != 33) begin fails++; $display("FAIL mulhu_latency: got %0d want 33", lat); end
    tests++; if (res !== 32'd1) begin fails++; $display("FAIL mulhu_result: got %h want 00000001", res); end
    run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0000, lat, res, z);
    tests++; if (res !== 32'd0) begin fails++; $display("FAIL mul_wrap_result: got %h want 0", res); end
    tests++; if (z !== 1'b1) begin fails++; $display("FAIL mul_wrap_zero: got %b want 1", z); end
  endtask

  task automatic test_div();
    int lat;
    logic [W-1:0] res;
    logic z;
    run_op(ALU_DIVU, 32'd100, 32'd7, lat, res, z);
    tests++; if (lat != 33) begin fails++; $display("FAIL divu_latency: got %0d want 33", lat); end
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL divu_result: got %h want 0000000e", res); end
    run_op(ALU_REMU, 32'd100, 32'd7, lat, res, z);
    tests++; if (lat != 33) begin fails++; $display("FAIL remu_latency: got %0d want 33", lat); end
    tests++; if (res !== 32'd2) begin fails++; $display("FAIL remu_result: got %h want 00000002", res); end
    run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, lat, res, z);
    tests++; if (res !== 32'h0000_FFFF) begin fails++; $display("FAIL divu_big_result: got %h want 0000ffff", res); end
    run_op(ALU_DIVU, 32'h1234_5678, 32'd0, lat, res, z);
    tests++; if (lat != 1) begin fails++; $display("FAIL divu0_latency: got %0d want 1", lat); end
    tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu0_result: got %h want ffffffff", res); end
    run_op(ALU_REMU, 32'd9, 32'd0, lat, res, z);
    tests++; if (lat != 1) begin fails++; $display("FAIL remu0_latency: got %0d want 1", lat); end
    tests++; if (res !== 32'd9) begin fails++; $display("FAIL remu0_result: got %h want 00000009", res); end
  endtask

  task automatic test_backpressure();
    out_ready  = 1'b0;
    alucontrol = ALU_ADD;
    srca       = 32'd1;
    srcb       = 32'd2;
    in_valid   = 1'b1;
    tick();
    // A second op is offered while the consumer stalls.
    alucontrol = ALU_SUB;
    srca       = 32'd10;
    srcb       = 32'd1;
    for (int i = 0; i < 5; i++) begin
      $display("[TB] stall cycle %0d: out_valid=%b in_ready=%b aluresult=%h", i, out_valid, in_ready, aluresult);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      tests++; if (aluresult !== 32'd3) begin fails++; $display("FAIL bp_hold[%0d]: got %h want 00000003", i, aluresult); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    tick();
    $display("[TB] release: out_valid=%b aluresult=%h", out_valid, aluresult);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    tests++; if (aluresult !== 32'd9) begin fails++; $display("FAIL bp_next_result: got %h want 00000009", aluresult); end
    in_valid = 1'b0;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_busy();
    int lat;
    int stray;
    logic [W-1:0] res;
    logic z;
    out_ready  = 1'b1;
    alucontrol = ALU_DIVU;
    srca       = 32'd1000;
    srcb       = 32'd3;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("[TB] reset mid-divu: in_ready=%b out_valid=%b aluresult=%h zero=%b",
             in_ready, out_valid, aluresult, zero);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rb_out_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rb_in_ready: got %b want 1", in_ready); end
    tests++; if (aluresult !== 32'd0) begin fails++; $display("FAIL rb_aluresult: got %h want 0", aluresult); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL rb_zero: got %b want 1", zero); end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) stray++;
      tick();
    end
    tests++; if (stray != 0) begin fails++; $display("FAIL rb_stray_result: got %0d valid cycles want 0", stray); end
    run_op(ALU_ADD, 32'd3, 32'd4, lat, res, z);
    tests++; if (lat != 1) begin fails++; $display("FAIL rb_add_latency: got %0d want 1", lat); end
    tests++; if (res !== 32'd7) begin fails++; $display("FAIL rb_add_result: got %h want 00000007", res); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
